// File: rtl/run_distributor_pkg.sv
// sort_pkg: shared FSM encoding, default data width and a clog2 helper
package sort_pkg;
    typedef enum logic {ST_FILL = 1'b0, ST_EMIT = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/run_distributor_if.sv
// run_distributor_if: input byte stream plus the push side of the two leaf FIFOs
interface run_distributor_if
    import sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             fifoA_push_n;
    logic             fifoA_full;
    logic [WIDTH-1:0] fifoA_data;
    logic             fifoB_push_n;
    logic             fifoB_full;
    logic [WIDTH-1:0] fifoB_data;
    logic             run_done;
    logic             target_b;
    modport slave (
        input  in_valid, in_data, in_last, fifoA_full, fifoB_full,
        output in_ready, fifoA_push_n, fifoA_data, fifoB_push_n, fifoB_data, run_done, target_b
    );
    modport master (
        output in_valid, in_data, in_last, fifoA_full, fifoB_full,
        input  in_ready, fifoA_push_n, fifoA_data, fifoB_push_n, fifoB_data, run_done, target_b
    );
endinterface

// File: rtl/run_distributor_sorted_insert_array.sv
// sorted_insert_array: ascending register array with stable parallel insert and shift-down pop
module sorted_insert_array
    import sort_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RUN_LEN = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_ins_en,
    input  logic                         i_shift_en,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_head,
    output logic [clog2(RUN_LEN+1)-1:0]  o_count
);
    localparam int CW = clog2(RUN_LEN + 1);
    logic [WIDTH-1:0]   r_arr  [RUN_LEN];
    logic [WIDTH-1:0]   w_next [RUN_LEN];
    logic [CW-1:0]      r_count;
    logic [RUN_LEN-1:0] w_gt;
    // Empty slots count as "greater", and strict > places ties after existing equals
    always_comb begin
        w_next = r_arr;
        for (int i = 0; i < RUN_LEN; i++)
            w_gt[i] = (i >= int'(r_count)) || (r_arr[i] > i_data);
        if (i_shift_en) begin
            for (int i = 0; i < RUN_LEN - 1; i++)
                w_next[i] = r_arr[i + 1];
            w_next[RUN_LEN - 1] = '0;
        end else if (i_ins_en) begin
            w_next[0] = w_gt[0] ? i_data : r_arr[0];
            for (int i = 1; i < RUN_LEN; i++)
                w_next[i] = !w_gt[i] ? r_arr[i] : (w_gt[i - 1] ? r_arr[i - 1] : i_data);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arr   <= '{default: '0};
            r_count <= '0;
        end else begin
            r_arr   <= w_next;
            r_count <= i_ins_en ? r_count + CW'(1) : (i_shift_en ? r_count - CW'(1) : r_count);
        end
    end
    assign o_head  = r_arr[0];
    assign o_count = r_count;
endmodule

// File: rtl/run_distributor.sv
// run_distributor: sorts input beats into runs and writes them alternately to leaf FIFOs A and B
module run_distributor
    import sort_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RUN_LEN = 4
) (
    input logic              clock,
    input logic              reset,
    run_distributor_if.slave bus
);
    localparam int CW = clog2(RUN_LEN + 1);
    state_t        r_state;
    logic          r_in_ready;
    logic          r_run_done;
    logic          r_target_b;
    logic          w_accept;
    logic          w_full;
    logic          w_push;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0] w_count;
    assign w_accept = bus.in_valid && r_in_ready && !reset;
    assign w_full   = r_target_b ? bus.fifoB_full : bus.fifoA_full;
    // Push is combinational on full so a stall costs no cycle; reset suppresses it
    assign w_push   = (r_state == ST_EMIT) && !w_full && !reset;
    sorted_insert_array #(.WIDTH(WIDTH), .RUN_LEN(RUN_LEN)) u_array (
        .clock      (clock),
        .reset      (reset),
        .i_ins_en   (w_accept),
        .i_shift_en (w_push),
        .i_data     (bus.in_data),
        .o_head     (w_head),
        .o_count    (w_count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_in_ready <= 1'b1;
            r_run_done <= 1'b0;
            r_target_b <= 1'b0;
        end else begin
            r_run_done <= 1'b0;
            if (w_accept && (bus.in_last || w_count == CW'(RUN_LEN - 1))) begin
                r_state    <= ST_EMIT;
                r_in_ready <= 1'b0;
            end
            if (w_push && w_count == CW'(1)) begin
                r_state    <= ST_FILL;
                r_in_ready <= 1'b1;
                r_run_done <= 1'b1;
                r_target_b <= !r_target_b;
            end
        end
    end
    assign bus.in_ready     = r_in_ready;
    assign bus.fifoA_push_n = !(w_push && !r_target_b);
    assign bus.fifoB_push_n = !(w_push && r_target_b);
    assign bus.fifoA_data   = w_head;
    assign bus.fifoB_data   = w_head;
    assign bus.run_done     = r_run_done;
    assign bus.target_b     = r_target_b;
endmodule
